// File: rtl/pma_region_table_if.sv
// Configuration and lookup bus of the PMA region table.
interface pma_region_table_if #(
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = 3
);
    typedef logic [NrPorts-1:0][AddrWidth-1:0] addr_vec_t;
    typedef logic [NrPorts-1:0][2:0]           attr_vec_t;
    typedef logic [NrPorts-1:0][IdxW-1:0]      rule_vec_t;

    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic [IdxW-1:0]      cfg_idx_i;
    logic [AddrWidth-1:0] cfg_base_i;
    logic [AddrWidth-1:0] cfg_len_i;
    logic [2:0]           cfg_attr_i;
    logic                 cfg_en_i;
    logic                 cfg_lock_i;
    logic                 cfg_err_o;

    logic [NrPorts-1:0]   req_valid_i;
    logic [NrPorts-1:0]   req_ready_o;
    addr_vec_t            req_addr_i;
    logic [NrPorts-1:0]   rsp_valid_o;
    logic [NrPorts-1:0]   rsp_ready_i;
    attr_vec_t            rsp_attr_o;
    logic [NrPorts-1:0]   rsp_hit_o;
    rule_vec_t            rsp_rule_o;

    modport master (
        output cfg_valid_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_en_i, cfg_lock_i,
        input  cfg_ready_o, cfg_err_o,
        output req_valid_i, req_addr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_attr_o, rsp_hit_o, rsp_rule_o
    );

    modport slave (
        input  cfg_valid_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_en_i, cfg_lock_i,
        output cfg_ready_o, cfg_err_o,
        input  req_valid_i, req_addr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_attr_o, rsp_hit_o, rsp_rule_o
    );
endinterface

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table with per-channel two-stage lookup pipelines.

// One lookup channel: S1 holds the address, S2 holds the resolved result.
module pma_lane #(
    parameter int unsigned NrRules     = 8,
    parameter int unsigned AddrWidth   = 64,
    parameter logic [2:0]  DefaultAttr = 3'b000,
    parameter int unsigned IdxW        = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrRules-1:0][AddrWidth-1:0]   base_i,
    input  logic [NrRules-1:0][AddrWidth-1:0]   len_i,
    input  logic [NrRules-1:0][2:0]             attr_i,
    input  logic [NrRules-1:0]                  en_i,
    input  logic                                drain_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [AddrWidth-1:0]                req_addr_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [2:0]                          rsp_attr_o,
    output logic                                rsp_hit_o,
    output logic [IdxW-1:0]                     rsp_rule_o,
    output logic                                s1_valid_o
);
    logic [1:0]           vld_pipe_q;   // [0] = S1, [1] = S2
    logic [AddrWidth-1:0] addr_q;
    logic [2:0]           attr_q;
    logic                 hit_q;
    logic [IdxW-1:0]      rule_q;
    logic                 adv, acc;
    logic [2:0]           m_attr;
    logic                 m_hit;
    logic [IdxW-1:0]      m_rule;

    assign adv         = !vld_pipe_q[1] || rsp_ready_i;
    assign req_ready_o = (!vld_pipe_q[0] || adv) && !drain_i;
    assign acc         = req_valid_i && req_ready_o;

    // Match S1 against every rule; descending scan leaves the lowest hit index in m_rule.
    always_comb begin
        m_attr = 3'b000;
        m_hit  = 1'b0;
        m_rule = '0;
        for (int k = int'(NrRules) - 1; k >= 0; k--) begin
            if (en_i[k] && (addr_q >= base_i[k]) &&
                ({1'b0, addr_q} < ({1'b0, base_i[k]} + {1'b0, len_i[k]}))) begin
                m_attr = m_attr | attr_i[k];
                m_hit  = 1'b1;
                m_rule = IdxW'(k);
            end
        end
        if (!m_hit) m_attr = DefaultAttr;
    end

    // Advance the pipeline; S2 only reloads when empty or drained downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q <= 2'b00;
            addr_q     <= '0;
            attr_q     <= 3'b000;
            hit_q      <= 1'b0;
            rule_q     <= '0;
        end else begin
            if (acc) begin
                vld_pipe_q[0] <= 1'b1;
                addr_q        <= req_addr_i;
            end else if (adv) begin
                vld_pipe_q[0] <= 1'b0;
            end
            if (adv) begin
                vld_pipe_q[1] <= vld_pipe_q[0];
                if (vld_pipe_q[0]) begin
                    attr_q <= m_attr;
                    hit_q  <= m_hit;
                    rule_q <= m_rule;
                end
            end
        end
    end

    assign rsp_valid_o = vld_pipe_q[1];
    assign rsp_attr_o  = attr_q;
    assign rsp_hit_o   = hit_q;
    assign rsp_rule_o  = rule_q;
    assign s1_valid_o  = vld_pipe_q[0];
endmodule

module pma_region_table #(
    parameter int unsigned NrRules     = 8,
    parameter int unsigned NrPorts     = 2,
    parameter int unsigned AddrWidth   = 64,
    parameter logic [2:0]  DefaultAttr = 3'b000,
    parameter int unsigned IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    pma_region_table_if.slave bus
);
    logic [NrRules-1:0][AddrWidth-1:0] base_q, len_q;
    logic [NrRules-1:0][2:0]           attr_q;
    logic [NrRules-1:0]                en_q, lock_q;
    logic                              err_q;
    logic [NrPorts-1:0]                s1_vld, req_rdy, rsp_vld, rsp_hit;
    logic [NrPorts-1:0][2:0]           rsp_attr;
    logic [NrPorts-1:0][IdxW-1:0]      rsp_rule;
    logic                              cfg_ready, idx_ok, locked, wr_ok;

    // A write is only taken once every S1 is empty, so no lookup straddles two table versions.
    assign cfg_ready = bus.cfg_valid_i && !(|s1_vld);
    assign idx_ok    = {{(32-IdxW){1'b0}}, bus.cfg_idx_i} < NrRules;
    assign wr_ok     = cfg_ready && idx_ok && !locked;

    // Lock bit of the addressed rule, without indexing past the table.
    always_comb begin
        locked = 1'b0;
        for (int k = 0; k < int'(NrRules); k++) begin
            if (bus.cfg_idx_i == IdxW'(k)) locked = lock_q[k];
        end
    end

    // Table storage; rejected writes leave it untouched and raise a one-cycle error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            len_q  <= '0;
            attr_q <= '0;
            en_q   <= '0;
            lock_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= cfg_ready && !(idx_ok && !locked);
            for (int k = 0; k < int'(NrRules); k++) begin
                if (wr_ok && (bus.cfg_idx_i == IdxW'(k))) begin
                    base_q[k] <= bus.cfg_base_i;
                    len_q[k]  <= bus.cfg_len_i;
                    attr_q[k] <= bus.cfg_attr_i;
                    en_q[k]   <= bus.cfg_en_i;
                    lock_q[k] <= bus.cfg_lock_i;
                end
            end
        end
    end

    for (genvar p = 0; p < NrPorts; p++) begin : g_lane
        pma_lane #(
            .NrRules(NrRules), .AddrWidth(AddrWidth), .DefaultAttr(DefaultAttr), .IdxW(IdxW)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .base_i      (base_q),
            .len_i       (len_q),
            .attr_i      (attr_q),
            .en_i        (en_q),
            .drain_i     (bus.cfg_valid_i),
            .req_valid_i (bus.req_valid_i[p]),
            .req_ready_o (req_rdy[p]),
            .req_addr_i  (bus.req_addr_i[p]),
            .rsp_valid_o (rsp_vld[p]),
            .rsp_ready_i (bus.rsp_ready_i[p]),
            .rsp_attr_o  (rsp_attr[p]),
            .rsp_hit_o   (rsp_hit[p]),
            .rsp_rule_o  (rsp_rule[p]),
            .s1_valid_o  (s1_vld[p])
        );
    end

    assign bus.cfg_ready_o = cfg_ready;
    assign bus.cfg_err_o   = err_q;
    assign bus.req_ready_o = req_rdy;
    assign bus.rsp_valid_o = rsp_vld;
    assign bus.rsp_attr_o  = rsp_attr;
    assign bus.rsp_hit_o   = rsp_hit;
    assign bus.rsp_rule_o  = rsp_rule;
endmodule

// File: tb/tb_pma_region_table.sv
// Scoreboard bench for pma_region_table: directed lookups, backpressure, drain, lock, reset.
module tb_pma_region_table;
    localparam int unsigned NR = 6;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 64;
    localparam int unsigned IW = 3;
    localparam logic [2:0]  DEF = 3'b100;

    typedef logic [6:0] exp_t;   // {attr, hit, rule}

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   cfg_applied = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    pma_region_table_if #(.NrPorts(NP), .AddrWidth(AW), .IdxW(IW)) bus ();

    pma_region_table #(
        .NrRules(NR), .NrPorts(NP), .AddrWidth(AW), .DefaultAttr(DEF), .IdxW(IW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    task automatic push(input int p, input exp_t e);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Issue one lookup; expected value chosen by whether the pending write has landed.
    task automatic lookup2(input int p, input logic [63:0] a, input exp_t e_old, input exp_t e_new);
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid_i[p] = 1'b1;
        bus.req_addr_i[p]  = a;
        forever begin
            @(negedge clk);
            if (bus.req_ready_o[p]) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            tests++; fails++;
            $display("FAIL req_timeout p%0d got no ready, required ready within 200 cycles", p);
        end else begin
            push(p, cfg_applied ? e_new : e_old);
        end
        @(posedge clk); #1;
        bus.req_valid_i[p] = 1'b0;
    endtask

    task automatic lookup(input int p, input logic [63:0] a, input exp_t e);
        lookup2(p, a, e, e);
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [63:0] base, input logic [63:0] len,
                             input logic [2:0] attr, input logic en, input logic lock, input logic exp_err);
        int n = 0;
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_idx_i   = idx;
        bus.cfg_base_i  = base;
        bus.cfg_len_i   = len;
        bus.cfg_attr_i  = attr;
        bus.cfg_en_i    = en;
        bus.cfg_lock_i  = lock;
        forever begin
            @(negedge clk);
            if (bus.cfg_ready_o) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            tests++; fails++;
            $display("FAIL cfg_timeout got no cfg_ready, required within 200 cycles");
        end else begin
            cfg_applied = 1'b1;
        end
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        tests++;
        if (bus.cfg_err_o !== exp_err) begin
            fails++;
            $display("FAIL cfg_err idx=%0d got %b required %b", idx, bus.cfg_err_o, exp_err);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.cfg_err_o !== 1'b0) begin
            fails++;
            $display("FAIL cfg_err_pulse idx=%0d got %b required 0", idx, bus.cfg_err_o);
        end
    endtask

    task automatic check1(input string nm, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got %0h required %0h", nm, got, req);
        end
    endtask

    // Monitor: pop and compare on every response handshake, check stall stability and drain gating.
    initial begin
        bit   held [NP];
        exp_t held_v [NP];
        exp_t got, e;
        for (int p = 0; p < int'(NP); p++) held[p] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                for (int p = 0; p < int'(NP); p++) held[p] = 1'b0;
            end else begin
                if (bus.cfg_valid_i) begin
                    tests++;
                    if (bus.req_ready_o !== '0) begin
                        fails++;
                        $display("FAIL drain_gate got req_ready=%b required 00", bus.req_ready_o);
                    end
                end
                for (int p = 0; p < int'(NP); p++) begin
                    got = {bus.rsp_attr_o[p], bus.rsp_hit_o[p], bus.rsp_rule_o[p]};
                    if (held[p]) begin
                        tests++;
                        if (!bus.rsp_valid_o[p] || got !== held_v[p]) begin
                            fails++;
                            $display("FAIL hold_p%0d got v=%b %h required v=1 %h", p, bus.rsp_valid_o[p], got, held_v[p]);
                        end
                    end
                    if (bus.rsp_valid_o[p] && bus.rsp_ready_i[p]) begin
                        held[p] = 1'b0;
                        tests++;
                        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                            fails++;
                            $display("FAIL rsp_p%0d got unexpected response %h required none", p, got);
                        end else begin
                            e = (p == 0) ? q0.pop_front() : q1.pop_front();
                            if (got !== e) begin
                                fails++;
                                $display("FAIL rsp_p%0d got attr=%b hit=%b rule=%0d required attr=%b hit=%b rule=%0d",
                                         p, got[6:4], got[3], got[2:0], e[6:4], e[3], e[2:0]);
                            end
                        end
                    end else if (bus.rsp_valid_o[p]) begin
                        held[p]   = 1'b1;
                        held_v[p] = got;
                    end else begin
                        held[p] = 1'b0;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        bus.cfg_valid_i = 1'b0;
        bus.cfg_idx_i   = '0;
        bus.cfg_base_i  = '0;
        bus.cfg_len_i   = '0;
        bus.cfg_attr_i  = '0;
        bus.cfg_en_i    = 1'b0;
        bus.cfg_lock_i  = 1'b0;
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.rsp_ready_i = '1;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // reset state
        @(negedge clk);
        check1("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
        check1("rst_rsp_attr",  64'(bus.rsp_attr_o),  64'h0);
        check1("rst_rsp_hit",   64'(bus.rsp_hit_o),   64'h0);
        check1("rst_rsp_rule",  64'(bus.rsp_rule_o),  64'h0);
        check1("rst_cfg_err",   64'(bus.cfg_err_o),   64'h0);

        // 1: empty table, latency
        lookup(0, 64'h8000_0000, {DEF, 1'b0, 3'd0});
        check1("lat_t1", 64'(bus.rsp_valid_o[0]), 64'h0);
        @(posedge clk); #1;
        check1("lat_t2", 64'(bus.rsp_valid_o[0]), 64'h1);

        // 2: single region, boundaries
        cfg_write(3'd2, 64'h8000_0000, 64'h1000, 3'b011, 1'b1, 1'b0, 1'b0);
        lookup(0, 64'h8000_0FFF, {3'b011, 1'b1, 3'd2});
        lookup(0, 64'h8000_1000, {DEF, 1'b0, 3'd0});
        lookup(1, 64'h8000_0000, {3'b011, 1'b1, 3'd2});
        lookup(1, 64'h7FFF_FFFF, {DEF, 1'b0, 3'd0});

        // 3: overlap, top-of-space, zero length
        cfg_write(3'd1, 64'h1000_0000, 64'h100, 3'b100, 1'b1, 1'b0, 1'b0);
        cfg_write(3'd3, 64'h0FFF_FF00, 64'h1000, 3'b010, 1'b1, 1'b0, 1'b0);
        cfg_write(3'd4, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 3'b001, 1'b1, 1'b0, 1'b0);
        cfg_write(3'd5, 64'h2000, 64'h0, 3'b001, 1'b1, 1'b0, 1'b0);
        lookup(0, 64'h1000_0000, {3'b110, 1'b1, 3'd1});
        lookup(0, 64'h0FFF_FF80, {3'b010, 1'b1, 3'd3});
        lookup(1, 64'hFFFF_FFFF_FFFF_FFFF, {3'b001, 1'b1, 3'd4});
        lookup(1, 64'h0, {DEF, 1'b0, 3'd0});
        lookup(0, 64'h2000, {DEF, 1'b0, 3'd0});

        // 4: both ports back-to-back with toggling backpressure
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i % 2 == 0) lookup(0, 64'h8000_0010, {3'b011, 1'b1, 3'd2});
                    else            lookup(0, 64'h1000_0000, {3'b110, 1'b1, 3'd1});
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i % 2 == 0) lookup(1, 64'h0FFF_FF80, {3'b010, 1'b1, 3'd3});
                    else            lookup(1, 64'h3, {DEF, 1'b0, 3'd0});
                end
            end
            begin
                logic [3:0] pat;
                pat = 4'b1001;
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    bus.rsp_ready_i[0] = pat[c % 4];
                    bus.rsp_ready_i[1] = pat[(c + 1) % 4];
                end
                @(posedge clk); #1;
                bus.rsp_ready_i = '1;
            end
        join

        // 5: write during a continuous stream
        cfg_applied = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    lookup2(0, 64'h8000_0100, {3'b011, 1'b1, 3'd2}, {3'b101, 1'b1, 3'd2});
            end
            begin
                repeat (3) @(posedge clk);
                cfg_write(3'd2, 64'h8000_0000, 64'h1000, 3'b101, 1'b1, 1'b0, 1'b0);
            end
        join

        // 6: lock and rejection
        cfg_write(3'd0, 64'h4000, 64'h100, 3'b001, 1'b1, 1'b1, 1'b0);
        lookup(0, 64'h4000, {3'b001, 1'b1, 3'd0});
        cfg_write(3'd0, 64'h4000, 64'h100, 3'b010, 1'b1, 1'b0, 1'b1);
        lookup(0, 64'h4000, {3'b001, 1'b1, 3'd0});
        cfg_write(3'd6, 64'h4000, 64'h100, 3'b010, 1'b1, 1'b0, 1'b1);
        lookup(1, 64'h4000, {3'b001, 1'b1, 3'd0});

        // drain outstanding responses before the reset scenario
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk); n++;
        end

        // reset mid-stream with a stalled pipeline
        bus.rsp_ready_i = '0;
        lookup(0, 64'h8000_0000, {3'b101, 1'b1, 3'd2});
        lookup(0, 64'h8000_0004, {3'b101, 1'b1, 3'd2});
        #1 rst_ni = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check1("rst_mid_valid", 64'(bus.rsp_valid_o), 64'h0);
        @(posedge clk); #1 rst_ni = 1'b1;
        bus.rsp_ready_i = '1;
        repeat (3) begin
            @(negedge clk);
            check1("rst_no_rsp", 64'(bus.rsp_valid_o), 64'h0);
        end
        cfg_write(3'd0, 64'h4000, 64'h100, 3'b010, 1'b1, 1'b0, 1'b0);
        lookup(0, 64'h4000, {3'b010, 1'b1, 3'd0});
        lookup(1, 64'h8000_0FFF, {DEF, 1'b0, 3'd0});

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk); n++;
        end
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain_end got %0d/%0d pending required 0/0", q0.size(), q1.size());
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pma_region_table.md
# pma_region_table

Runtime-programmable physical-memory-attribute lookup unit for the CVA6 memory subsystem. It holds `NrRules` base/length regions, each tagged with an attribute mask (execute, cacheable, non-idempotent). It answers address lookups on `NrPorts` independent two-stage pipelined channels with valid/ready handshakes. Configuration writes are ordered against in-flight lookups, so every lookup sees exactly one table version.

## Interface
Parameters:
- `NrRules`, 8 — number of table entries; legal range 1..16.
- `NrPorts`, 2 — number of independent lookup channels; legal range ≥1.
- `AddrWidth`, 64 — address width; legal range ≤64.
- `DefaultAttr`, 3'b000 — attribute mask returned when no enabled rule matches.
- `IdxW`, `$clog2(NrRules)` with a minimum of 1 — derived; do not override.

Ports:
- `clk_i`, in, 1 — clock.
- `rst_ni`, in, 1 — reset. Asynchronous, active-low; one clock domain.
- `cfg_valid_i`, in, 1 — configuration write request.
- `cfg_ready_o`, out, 1 — configuration write accepted this cycle.
- `cfg_idx_i`, in, IdxW — index of the rule to write.
- `cfg_base_i`, in, AddrWidth — region base address.
- `cfg_len_i`, in, AddrWidth — region length in bytes.
- `cfg_attr_i`, in, 3 — attribute mask: {NI, C, X}.
- `cfg_en_i`, in, 1 — rule enable.
- `cfg_lock_i`, in, 1 — rule lock; sticky until reset.
- `cfg_err_o`, out, 1 — one-cycle pulse when a write is rejected.
- `req_valid_i`, in, NrPorts — lookup request per channel.
- `req_ready_o`, out, NrPorts — lookup accepted per channel.
- `req_addr_i`, in, NrPorts×AddrWidth — lookup address per channel.
- `rsp_valid_o`, out, NrPorts — lookup result valid per channel.
- `rsp_ready_i`, in, NrPorts — consumer ready per channel.
- `rsp_attr_o`, out, NrPorts×3 — result attribute mask.
- `rsp_hit_o`, out, NrPorts — at least one enabled rule matched.
- `rsp_rule_o`, out, NrPorts×IdxW — lowest-index matching rule; 0 when there is no hit.

## Operation
Match rule:
- Rule k matches address a when the rule is enabled, `a >= base`, and `{1'b0,a} < base + len`.
- The sum `base + len` is computed at AddrWidth+1 bits, so it never wraps.
- A rule with `len == 0` never matches.

Result formation:
- `rsp_attr_o` is the bitwise OR of the attribute masks of all matching rules.
- If no rule matches, `rsp_attr_o = DefaultAttr`.
- `rsp_rule_o` is the lowest matching index (priority encoder).

Lookup pipeline, per channel:
- S1 is the address register. The table match is evaluated combinationally from S1.
- S2 is the result register, holding attr, hit and rule.
- S2 loads when it is empty or `rsp_ready_i` is high. S1 advances into S2 under the same condition.
- `req_ready_o[p] = !S1_valid[p] || S1 advances`, gated by the drain condition below.

Configuration ordering:
- `cfg_ready_o = cfg_valid_i && !(|S1_valid)`.
- While `cfg_valid_i` is high, all `req_ready_o` are forced low, so the pipelines drain and the write cannot starve.
- An accepted write updates the table at the clock edge.
- A lookup accepted into S1 in any later cycle sees the new table.
- S2 contents are already resolved and are unaffected by the write.

Write rejection:
- A write to a locked rule is rejected: the table is unchanged and `cfg_err_o` pulses for one cycle.
- A write with `cfg_idx_i >= NrRules` is rejected the same way.
- Rejected writes still complete the handshake (`cfg_ready_o` high).

Channel independence:
- Channels never block one another except through the configuration drain.

Reset:
- All rules are cleared: base 0, len 0, attr 0, disabled, unlocked.
- All S1/S2 valid bits are 0.
- `rsp_valid_o = 0`, `rsp_attr_o = 0`, `rsp_hit_o = 0`, `rsp_rule_o = 0`, `cfg_err_o = 0`.
- Reset in the middle of an operation discards in-flight lookups; no response is produced for them.

## Timing
- Latency: a request accepted at edge t gives `rsp_valid_o` high after edge t+1. This is a 2-cycle registered path with no combinational path from request to response.
- Throughput: one lookup per cycle per channel while `rsp_ready_i` is held high.
- Backpressure: when `rsp_ready_i` is low with S1 and S2 full, `req_ready_o` drops in the same cycle.
- Held response: while stalled, `rsp_*` outputs stay stable until the handshake completes.
- Configuration write: completes 1–2 cycles after `cfg_valid_i` rises when the response side is unblocked; it is unbounded while `rsp_ready_i` is held low.
- Simultaneous write and lookup: a `cfg_valid_i`/`req_valid_i` collision in the same cycle gives the write priority.
- `cfg_err_o`: registered; high during the cycle after the rejected handshake.

## Test plan
1. Reset, then lookup of 0x8000_0000 on port 0 → `rsp_valid_o` at t+2, hit=0, attr=`DefaultAttr`, rule=0.
2. Program rule 2 = {base 0x8000_0000, len 0x1000, attr X|C, en}. Look up 0x8000_0FFF → hit, attr 3'b011, rule 2. Look up 0x8000_1000 → no hit.
3. Program overlapping rules 1 (NI) and 3 (C) covering 0x1000_0000 → attr 3'b110, rule 1. Program base 0xFFFF_FFFF_FFFF_F000 with len 0x2000; look up 0xFFFF_FFFF_FFFF_FFFF → hit, no wrap artefact.
4. Drive back-to-back requests on both ports with `rsp_ready_i` toggling 1,0,0,1 → no response lost or duplicated, results in order, outputs held stable while stalled.
5. Assert `cfg_valid_i` during a continuous request stream → `req_ready_o` low until S1 drains, then write accepted. The first post-write lookup sees the new attributes; the lookups before it see the old ones.
6. Lock rule 0, then write rule 0 and write index `NrRules` → `cfg_err_o` pulses each time and the table is unchanged. Assert `rst_ni` low mid-stream → all valid bits clear and the lock is released.
